// File: rtl/addsub_pkg.sv
// Shared types and constants for the 16-bit accumulator stage around the add/sub unit.
// Saturation values are used only when ADDSUB_ACC_SAT_EN is defined.
package addsub_pkg;

  typedef enum logic [1:0] {
    CMD_ADD   = 2'b00,
    CMD_SUB   = 2'b01,
    CMD_LOAD  = 2'b10,
    CMD_CLRST = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // out_flags = {sticky_ovf, ovf, carry, neg, zero}
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_NEG    = 1;
  localparam int FLAG_CARRY  = 2;
  localparam int FLAG_OVF    = 3;
  localparam int FLAG_STICKY = 4;
  localparam int FLAG_W      = 5;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational next-accumulator and flag logic for one executed command.
// Option ADDSUB_ACC_SAT_EN: on add/sub overflow write SAT_POS/SAT_NEG instead of the wrapped sum.
module addsub_flag_gen
  import addsub_pkg::*;
(
  input  cmd_t              cmd,
  input  logic [15:0]       acc,
  input  logic [15:0]       opnd,
  input  logic [15:0]       add_sum,
  input  logic              add_cout,
  input  logic              add_ovf,
  input  logic              sticky,
  output logic [15:0]       acc_new,
  output logic [FLAG_W-1:0] flags_new
);

  logic carry_new;
  logic ovf_new;
  logic sticky_new;

  always_comb begin
    acc_new    = acc;
    carry_new  = 1'b0;
    ovf_new    = 1'b0;
    sticky_new = sticky;
    case (cmd)
      CMD_ADD, CMD_SUB: begin
`ifdef ADDSUB_ACC_SAT_EN
        // Direction of overflow follows the sign of the accumulator operand.
        if (add_ovf) acc_new = acc[15] ? SAT_NEG : SAT_POS;
        else         acc_new = add_sum;
`else
        acc_new = add_sum;
`endif
        carry_new  = add_cout;
        ovf_new    = add_ovf;
        sticky_new = sticky | add_ovf;
      end
      CMD_LOAD:  acc_new = opnd;
      CMD_CLRST: sticky_new = 1'b0;
      default:   acc_new = acc;
    endcase
  end

  always_comb begin
    flags_new              = '0;
    flags_new[FLAG_ZERO]   = (acc_new == 16'h0000);
    flags_new[FLAG_NEG]    = acc_new[15];
    flags_new[FLAG_CARRY]  = carry_new;
    flags_new[FLAG_OVF]    = ovf_new;
    flags_new[FLAG_STICKY] = sticky_new;
  end

endmodule

// File: rtl/addsub16_accum.sv
// Accumulator stage: accepts a command, drives the external add/sub unit for one EXEC cycle,
// then holds the result until taken. Option ADDSUB_ACC_SAT_EN enables saturating add/sub.
module addsub16_accum
  import addsub_pkg::*;
#(
  parameter logic [15:0] ACC_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // Both handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and in_ready/out_valid are pure state decodes.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cmd,
  input  logic [15:0] in_opnd,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_ctrl,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  input  logic        add_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_acc,
  output logic [4:0]  out_flags,
  output logic [1:0]  dbg_state
);

  state_t              state, state_n;
  cmd_t                cmd_q;
  logic [15:0]         opnd_q;
  logic [15:0]         acc;
  logic [FLAG_W-1:0]   flags;
  logic [15:0]         acc_new;
  logic [FLAG_W-1:0]   flags_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid)  state_n = ST_EXEC;
      ST_EXEC:                state_n = ST_HOLD;
      ST_HOLD: if (out_ready) state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= CMD_ADD;
      opnd_q <= 16'h0000;
      acc    <= ACC_RST;
      flags  <= '0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        cmd_q  <= cmd_t'(in_cmd);
        opnd_q <= in_opnd;
      end
      if (state == ST_EXEC) begin
        acc   <= acc_new;
        flags <= flags_new;
      end
    end
  end

  addsub_flag_gen u_flag_gen (
    .cmd       (cmd_q),
    .acc       (acc),
    .opnd      (opnd_q),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .add_ovf   (add_ovf),
    .sticky    (flags[FLAG_STICKY]),
    .acc_new   (acc_new),
    .flags_new (flags_new)
  );

  // Unit inputs are driven straight from registers; the unit result only matters in EXEC.
  assign add_a     = acc;
  assign add_b     = opnd_q;
  assign add_ctrl  = (cmd_q == CMD_SUB);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_HOLD);
  assign out_acc   = acc;
  assign out_flags = flags;
  assign dbg_state = state;

endmodule

// File: tb/tb_addsub16_accum.sv
// Self-checking bench for addsub16_accum with a behavioural add/sub unit and reference model.
module tb_addsub16_accum;

  localparam logic [15:0] ACC_RST_TB = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_cmd;
  logic [15:0] in_opnd;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_ctrl, add_cout, add_ovf;
  logic        out_valid, out_ready;
  logic [15:0] out_acc;
  logic [4:0]  out_flags;
  logic [1:0]  dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // scoreboard
  logic [15:0] exp_q[$];
  logic [4:0]  exp_f_q[$];

  // reference model state
  logic [15:0] m_acc;
  logic        m_carry, m_ovf, m_sticky;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  addsub16_accum #(.ACC_RST(ACC_RST_TB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cmd    (in_cmd),
    .in_opnd   (in_opnd),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ctrl  (add_ctrl),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .add_ovf   (add_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_flags (out_flags),
    .dbg_state (dbg_state)
  );

  // the real combinational add/sub unit, attached at parent level
  logic [15:0] bb;
  logic [16:0] wide;
  always_comb begin
    bb       = add_ctrl ? ~add_b : add_b;
    wide     = {1'b0, add_a} + {1'b0, bb} + {16'h0000, add_ctrl};
    add_sum  = wide[15:0];
    add_cout = wide[16];
    add_ovf  = (add_a[15] == bb[15]) && (wide[15] != add_a[15]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_flags();
    return {m_sticky, m_ovf, m_carry, m_acc[15], (m_acc == 16'h0000)};
  endfunction

  // behavioural model: signed/unsigned integer arithmetic on the command rules
  task automatic model_apply(input logic [1:0] cmd, input logic [15:0] op);
    int sa, sb, ua, ub, r;
    sa = $signed(m_acc);
    sb = $signed(op);
    ua = {16'h0000, m_acc};
    ub = {16'h0000, op};
    case (cmd)
      2'b00, 2'b01: begin
        if (cmd == 2'b00) begin
          r       = sa + sb;
          m_carry = (ua + ub) > 65535;
        end else begin
          r       = sa - sb;
          m_carry = (ua >= ub);
        end
        m_ovf    = (r > 32767) || (r < -32768);
        m_sticky = m_sticky | m_ovf;
`ifdef ADDSUB_ACC_SAT_EN
        if (r > 32767)       m_acc = 16'h7FFF;
        else if (r < -32768) m_acc = 16'h8000;
        else                 m_acc = r[15:0];
`else
        m_acc = r[15:0];
`endif
      end
      2'b10: begin
        m_acc   = op;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
      end
      default: begin
        m_carry  = 1'b0;
        m_ovf    = 1'b0;
        m_sticky = 1'b0;
      end
    endcase
  endtask

  task automatic model_reset();
    m_acc    = ACC_RST_TB;
    m_carry  = 1'b0;
    m_ovf    = 1'b0;
    m_sticky = 1'b0;
    exp_q.delete();
    exp_f_q.delete();
  endtask

  // driver: one full transaction, called at a negedge with the DUT idle
  task automatic send(input logic [1:0] cmd, input logic [15:0] op, input int hold);
    logic [15:0] acc_before, e_acc;
    logic [4:0]  e_flags;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    acc_before = m_acc;
    in_valid  = 1'b1;
    in_cmd    = cmd;
    in_opnd   = op;
    out_ready = (hold == 0);
    model_apply(cmd, op);
    exp_q.push_back(m_acc);
    exp_f_q.push_back(m_flags());
    @(negedge clk);
    // EXEC: stray in_valid must be ignored
    in_valid = 1'(($urandom_range(0, 1)));
    in_cmd   = 2'($urandom_range(0, 3));
    in_opnd  = 16'($urandom);
    chk("exec_in_ready", in_ready, 0);
    chk("exec_out_valid", out_valid, 0);
    chk("exec_add_a", add_a, acc_before);
    chk("exec_add_b", add_b, op);
    chk("exec_add_ctrl", add_ctrl, (cmd == 2'b01));
    @(negedge clk);
    e_acc   = exp_q.pop_front();
    e_flags = exp_f_q.pop_front();
    chk("hold_out_valid", out_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_out_acc", out_acc, e_acc);
    chk("hold_out_flags", out_flags, e_flags);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      in_cmd   = 2'($urandom_range(0, 3));
      in_opnd  = 16'($urandom);
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_acc", out_acc, e_acc);
      chk("stall_out_flags", out_flags, e_flags);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_out_acc", out_acc, e_acc);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_acc"}, out_acc, ACC_RST_TB);
    chk({tag, "_flags"}, out_flags, 5'b00000);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_add_b"}, add_b, 16'h0000);
    chk({tag, "_add_ctrl"}, add_ctrl, 0);
  endtask

  function automatic logic [15:0] pick_opnd();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0001;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cmd    = 2'b00;
    in_opnd   = 16'h0000;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD, then positive overflow, then sticky behaviour through ADD and CLRST
    send(2'b10, 16'h1234, 0);
    chk("load_value", out_acc, 16'h1234);
    send(2'b10, 16'h7FFF, 0);
    send(2'b00, 16'h0001, 0);
`ifdef ADDSUB_ACC_SAT_EN
    chk("ovf_sat_acc", out_acc, 16'h7FFF);
`else
    chk("ovf_wrap_acc", out_acc, 16'h8000);
`endif
    chk("ovf_flag", out_flags[3], 1);
    chk("ovf_sticky", out_flags[4], 1);
    send(2'b00, 16'h0001, 0);
    chk("sticky_kept", out_flags[4], 1);
    send(2'b11, 16'hBEEF, 0);
    chk("sticky_cleared", out_flags[4], 0);

    // SUB to zero
    send(2'b10, 16'h0005, 0);
    send(2'b01, 16'h0005, 0);
    chk("sub_zero_acc", out_acc, 16'h0000);
    chk("sub_zero_flag", out_flags[0], 1);

    // negative overflow and back-pressure stall with toggling in_valid
    send(2'b10, 16'h8000, 0);
    send(2'b01, 16'h0001, 5);

    // reset during EXEC discards the command
    in_valid = 1'b1;
    in_cmd   = 2'b10;
    in_opnd  = 16'hA5A5;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_rst");

    // randomized commands
    for (int n = 0; n < 60; n++) begin
      send(2'($urandom_range(0, 3)), pick_opnd(), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
